// File: rtl/adc_pkg.sv
// Shared ADC definitions: sample width, channel addresses and helpers
// used by both the SPI ADC interface and the moving-average filter.
package adc_pkg;

    // Conversion result width of the SPI ADC.
    localparam int ADC_DATA_W    = 12;

    // Channel-address constants for the ADC multiplexer.
    localparam int ADC_CH_ADDR_W = 3;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH0 = 3'd0;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH1 = 3'd1;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH2 = 3'd2;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH3 = 3'd3;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH4 = 3'd4;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH5 = 3'd5;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH6 = 3'd6;
    localparam logic [ADC_CH_ADDR_W-1:0] ADC_CH7 = 3'd7;

    // Window phase; derived from the fill count, never stored separately.
    typedef enum logic {
        WIN_PRIMING = 1'b0,
        WIN_FULL    = 1'b1
    } window_phase_t;

    // Half-LSB rounding term for a divide by 2**log2_depth (0 for a window of 1).
    function automatic int round_term(input int log2_depth);
        if (log2_depth == 0) begin
            return 0;
        end
        return 1 << (log2_depth - 1);
    endfunction

endpackage

// File: rtl/adc_moving_average_if.sv
// Sample-in / average-out bundle between the ADC front end and the
// moving-average filter. master = sample producer, slave = filter.
interface adc_moving_average_if #(
    parameter int DATA_W     = 12,
    parameter int LOG2_DEPTH = 3
) ();

    logic [DATA_W-1:0]     sample_in;
    logic                  sample_valid;
    logic                  clear;
    logic [DATA_W-1:0]     avg_out;
    logic                  avg_valid;
    logic                  window_full;
    logic [LOG2_DEPTH:0]   fill_count;

    modport master (
        output sample_in,
        output sample_valid,
        output clear,
        input  avg_out,
        input  avg_valid,
        input  window_full,
        input  fill_count
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        input  clear,
        output avg_out,
        output avg_valid,
        output window_full,
        output fill_count
    );

endinterface

// File: rtl/adc_moving_average_sample_ring_buf.sv
// Ring buffer of the last 2**LOG2_DEPTH samples. Presents the entry at
// the write pointer (the oldest sample once the window is full) so the
// caller can subtract it in the same cycle the new sample overwrites it.
module sample_ring_buf
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              ptr_clr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  wr_sel;

    // One-hot write select per storage entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Pointer advance with explicit wrap so non-power-of-two pointer widths stay safe.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        if (ptr_clr) begin
            wr_ptr_next = '0;
        end else if (wr_en) begin
            if (wr_ptr_reg == PTR_W'(DEPTH - 1)) begin
                wr_ptr_next = '0;
            end else begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Write pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // Sample storage; contents are qualified by the fill count, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_reg[i] <= wr_data;
            end
        end
    end

    // Read-before-write of the slot about to be overwritten.
    generate
        if (DEPTH == 1) begin : g_rd_single
            assign oldest_data = mem_reg[0];
        end else begin : g_rd_multi
            assign oldest_data = mem_reg[wr_ptr_reg];
        end
    endgenerate

endmodule

// File: rtl/adc_moving_average.sv
// Moving-average filter for the 12-bit SPI ADC. Keeps a running sum over
// the last 2**LOG2_DEPTH accepted samples and emits the round-half-up mean
// with a one-cycle valid pulse whenever an accept leaves the window full.
module adc_moving_average
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_moving_average_if.slave  bus
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam int RND   = round_term(LOG2_DEPTH);

    logic                accept;
    window_phase_t       phase;
    logic [DATA_W-1:0]   buf_oldest;
    logic [DATA_W-1:0]   oldest;

    logic [SUM_W-1:0]    sum_reg;
    logic [SUM_W-1:0]    sum_next;
    logic [SUM_W-1:0]    sum_acc;
    logic [SUM_W:0]      avg_wide;
    logic [DATA_W-1:0]   avg_calc;

    logic [CNT_W-1:0]    fill_count_reg;
    logic [CNT_W-1:0]    fill_count_next;
    logic                window_full_reg;
    logic                window_full_next;
    logic [DATA_W-1:0]   avg_out_reg;
    logic [DATA_W-1:0]   avg_out_next;
    logic                avg_valid_reg;
    logic                avg_valid_next;

    // clear wins over a coincident sample, which is then dropped.
    assign accept = bus.sample_valid && !bus.clear;

    sample_ring_buf #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (accept),
        .ptr_clr     (bus.clear),
        .wr_data     (bus.sample_in),
        .oldest_data (buf_oldest)
    );

    // Phase is implied by the fill count; while priming the evicted value is zero.
    always_comb begin
        phase  = (fill_count_reg == CNT_W'(DEPTH)) ? WIN_FULL : WIN_PRIMING;
        oldest = (phase == WIN_FULL) ? buf_oldest : '0;
    end

    // Running sum and rounded mean. The sum never exceeds DEPTH*(2**DATA_W-1),
    // so the add-then-subtract fits in SUM_W bits without a wider intermediate.
    always_comb begin
        sum_acc  = sum_reg + SUM_W'(bus.sample_in) - SUM_W'(oldest);
        avg_wide = {1'b0, sum_acc} + (SUM_W + 1)'(RND);
        avg_calc = DATA_W'(avg_wide >> LOG2_DEPTH);
    end

    // Next-state for sum, fill level and outputs.
    always_comb begin
        sum_next        = sum_reg;
        fill_count_next = fill_count_reg;
        if (bus.clear) begin
            sum_next        = '0;
            fill_count_next = '0;
        end else if (accept) begin
            sum_next = sum_acc;
            if (phase == WIN_PRIMING) begin
                fill_count_next = fill_count_reg + CNT_W'(1);
            end
        end
        window_full_next = (fill_count_next == CNT_W'(DEPTH));
        avg_valid_next   = accept && window_full_next;
        avg_out_next     = avg_valid_next ? avg_calc : avg_out_reg;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg         <= '0;
            fill_count_reg  <= '0;
            window_full_reg <= 1'b0;
            avg_out_reg     <= '0;
            avg_valid_reg   <= 1'b0;
        end else begin
            sum_reg         <= sum_next;
            fill_count_reg  <= fill_count_next;
            window_full_reg <= window_full_next;
            avg_out_reg     <= avg_out_next;
            avg_valid_reg   <= avg_valid_next;
        end
    end

    assign bus.avg_out     = avg_out_reg;
    assign bus.avg_valid   = avg_valid_reg;
    assign bus.window_full = window_full_reg;
    assign bus.fill_count  = fill_count_reg;

endmodule

// File: tb/tb_adc_moving_average.sv
// Self-checking bench for adc_moving_average: directed scenarios plus a
// randomized run, all compared against a queue-based window model.
module tb_adc_moving_average;
    import adc_pkg::*;

    localparam int DATA_W     = ADC_DATA_W;
    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 1 << LOG2_DEPTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adc_moving_average_if #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) bus ();

    adc_moving_average #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: the window is simply the last DEPTH accepted samples.
    int model_q[$];
    int model_avg   = 0;
    bit model_valid = 1'b0;
    int valid_seen  = 0;

    task automatic check_value(input string tag, input longint observed, input longint expected);
        n_compared++;
        if (observed != expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (model_q[i]) s += model_q[i];
        return s;
    endfunction

    function automatic void model_reset();
        model_q.delete();
        model_avg   = 0;
        model_valid = 1'b0;
    endfunction

    // One clock cycle with the given inputs; checks every output afterwards.
    task automatic tick(input bit v, input int d, input bit c);
        logic [DATA_W-1:0] d_trunc;
        d_trunc          = d[DATA_W-1:0];
        bus.sample_valid = v;
        bus.sample_in    = d_trunc;
        bus.clear        = c;
        @(posedge clk);
        model_valid = 1'b0;
        if (c) begin
            model_q.delete();
        end else if (v) begin
            model_q.push_back(int'(d_trunc));
            if (model_q.size() > DEPTH) void'(model_q.pop_front());
            if (model_q.size() == DEPTH) begin
                model_avg   = (model_sum() + DEPTH / 2) / DEPTH;
                model_valid = 1'b1;
            end
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b0;
        if (bus.avg_valid) valid_seen++;
        check_value("fill_count",  bus.fill_count,  model_q.size());
        check_value("window_full", bus.window_full, (model_q.size() == DEPTH) ? 1 : 0);
        check_value("avg_valid",   bus.avg_valid,   model_valid);
        check_value("avg_out",     bus.avg_out,     model_avg);
        check_value("sum",         dut.sum_reg,     model_sum());
        if (v && !c)
            $display("accept d=%0d fill=%0d avg=%0d valid=%0b",
                     d_trunc, bus.fill_count, bus.avg_out, bus.avg_valid);
        else if (c)
            $display("clear  fill=%0d avg=%0d", bus.fill_count, bus.avg_out);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_avg_out"},     bus.avg_out,     0);
        check_value({tag, "_avg_valid"},   bus.avg_valid,   0);
        check_value({tag, "_window_full"}, bus.window_full, 0);
        check_value({tag, "_fill_count"},  bus.fill_count,  0);
        check_value({tag, "_sum"},         dut.sum_reg,     0);
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        $display("reset pulse");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.clear        = 1'b0;
        rst              = 1'b1;

        // 1: reset, then idle with no avg_valid.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        valid_seen = 0;
        repeat (20) tick(1'b0, 0, 1'b0);
        check_value("t1_no_valid", valid_seen, 0);

        // 2: eight spaced accepts of 1000.
        valid_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1000, 1'b0);
            check_value("t2_fill", bus.fill_count, k + 1);
            repeat (15) tick(1'b0, 0, 1'b0);
        end
        check_value("t2_valid_pulses", valid_seen, 1);
        check_value("t2_avg", bus.avg_out, 1000);
        check_value("t2_full", bus.window_full, 1);

        // 3: replace the window with 2000s, mean steps by 125.
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 2000, 1'b0);
            check_value("t3_avg", bus.avg_out, 1000 + 125 * k);
            check_value("t3_valid", bus.avg_valid, 1);
        end

        // 4: rounding of 1.5 and the full-scale window.
        tick(1'b0, 0, 1'b1);
        for (int k = 0; k < 8; k++) tick(1'b1, (k < 4) ? 1 : 2, 1'b0);
        check_value("t4_round", bus.avg_out, 2);
        for (int k = 0; k < 8; k++) tick(1'b1, 4095, 1'b0);
        check_value("t4_fullscale_avg", bus.avg_out, 4095);
        check_value("t4_fullscale_sum", dut.sum_reg, 32760);

        // 5: back-to-back accepts 0..7.
        tick(1'b0, 0, 1'b1);
        valid_seen = 0;
        for (int k = 0; k < 8; k++) tick(1'b1, k, 1'b0);
        repeat (4) tick(1'b0, 0, 1'b0);
        check_value("t5_avg", bus.avg_out, 4);
        check_value("t5_valid_pulses", valid_seen, 1);

        // 6: clear beats a coincident sample; reset mid-window restarts priming.
        tick(1'b0, 0, 1'b1);
        for (int k = 0; k < 5; k++) tick(1'b1, $urandom_range(4095), 1'b0);
        tick(1'b1, 3000, 1'b1);
        check_value("t6_clear_fill", bus.fill_count, 0);
        check_value("t6_clear_sum", dut.sum_reg, 0);
        check_value("t6_clear_avg_hold", bus.avg_out, 4);
        for (int k = 0; k < 3; k++) tick(1'b1, 500, 1'b0);
        pulse_reset();
        valid_seen = 0;
        for (int k = 0; k < 7; k++) tick(1'b1, 700, 1'b0);
        check_value("t6_no_early_valid", valid_seen, 0);
        check_value("t6_fill7", bus.fill_count, 7);
        tick(1'b1, 700, 1'b0);
        check_value("t6_valid_on_8th", valid_seen, 1);
        check_value("t6_avg", bus.avg_out, 700);

        // 7: randomized traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(99);
            tick(1'($urandom_range(1)), $urandom_range(4095), r < 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
